// File: rtl/board_sequencer_pkg.sv
// Shared Game-of-Life board dimensions and sequencer state encoding.
package board_sequencer_pkg;

  localparam int GOL_WIDTH  = 20;
  localparam int GOL_HEIGHT = 20;
  localparam int GOL_RW     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/board_sequencer_if.sv
// Host / row_calculator / display bundle for the board sequencer.
interface board_sequencer_if
  import board_sequencer_pkg::*;
#(
  parameter int WIDTH = GOL_WIDTH,
  parameter int RW    = GOL_RW
);

  logic             load_i;
  logic [RW-1:0]    load_row_i;
  logic [WIDTH-1:0] load_data_i;
  logic             step_i;
  logic             busy_o;
  logic             done_o;
  logic             extinct_o;
  logic [15:0]      gen_count_o;
  logic [WIDTH-1:0] calc_arriba_o;
  logic [WIDTH-1:0] calc_medio_o;
  logic [WIDTH-1:0] calc_abajo_o;
  logic [WIDTH-1:0] calc_new_i;
  logic [RW-1:0]    rd_row_i;
  logic [WIDTH-1:0] rd_data_o;

  modport master (
    output load_i, load_row_i, load_data_i, step_i, calc_new_i, rd_row_i,
    input  busy_o, done_o, extinct_o, gen_count_o,
           calc_arriba_o, calc_medio_o, calc_abajo_o, rd_data_o
  );

  modport slave (
    input  load_i, load_row_i, load_data_i, step_i, calc_new_i, rd_row_i,
    output busy_o, done_o, extinct_o, gen_count_o,
           calc_arriba_o, calc_medio_o, calc_abajo_o, rd_data_o
  );

endinterface

// File: rtl/board_sequencer.sv
// Holds the Life board and walks it one row per cycle through the external
// row_calculator, writing each next-state row back in place.
module board_sequencer
  import board_sequencer_pkg::*;
#(
  parameter int WIDTH  = GOL_WIDTH,
  parameter int HEIGHT = GOL_HEIGHT,
  parameter int RW     = GOL_RW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  board_sequencer_if.slave bus
);

  logic [WIDTH-1:0] board [HEIGHT];
  state_t           state;
  logic [RW-1:0]    r;
  logic [RW-1:0]    r_nxt;
  logic [WIDTH-1:0] prev_row;
  logic             acc;
  logic             extinct;
  logic [15:0]      gen_count;
  logic             last_row;

  assign r_nxt    = r + RW'(1);
  assign last_row = (r == RW'(HEIGHT - 1));

  assign bus.busy_o      = (state == S_RUN);
  assign bus.done_o      = (state == S_DONE);
  assign bus.extinct_o   = extinct;
  assign bus.gen_count_o = gen_count;

  // prev_row keeps the pre-update copy of row r-1, since board[r-1] is already overwritten
  always_comb begin
    bus.calc_arriba_o = '0;
    bus.calc_medio_o  = '0;
    bus.calc_abajo_o  = '0;
    if (state == S_RUN) begin
      bus.calc_medio_o = board[r];
      if (!last_row) bus.calc_abajo_o = board[r_nxt];
      if (r != '0)   bus.calc_arriba_o = prev_row;
    end
  end

  always_comb begin
    bus.rd_data_o = '0;
    if (int'(bus.rd_row_i) < HEIGHT) bus.rd_data_o = board[bus.rd_row_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      r         <= '0;
      prev_row  <= '0;
      acc       <= 1'b0;
      extinct   <= 1'b0;
      gen_count <= '0;
      for (int i = 0; i < HEIGHT; i++) board[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A simultaneous load wins; the step request is dropped.
          if (bus.load_i) begin
            if (int'(bus.load_row_i) < HEIGHT) board[bus.load_row_i] <= bus.load_data_i;
          end else if (bus.step_i) begin
            state <= S_RUN;
            r     <= '0;
          end
        end
        S_RUN: begin
          board[r] <= bus.calc_new_i;
          prev_row <= board[r];
          acc      <= acc | (|bus.calc_new_i);
          r        <= r_nxt;
          if (last_row) begin
            state     <= S_DONE;
            r         <= '0;
            gen_count <= gen_count + 16'd1;
            extinct   <= ~(acc | (|bus.calc_new_i));
          end
        end
        S_DONE: begin
          acc   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_sequencer.sv
// Directed bench for board_sequencer with a behavioural Life row calculator.
module tb_board_sequencer;

  localparam int W = 20;
  localparam int H = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_sequencer_if #(.WIDTH(W), .RW(R)) bus ();

  board_sequencer #(.WIDTH(W), .HEIGHT(H), .RW(R)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  function automatic logic [W-1:0] life(input logic [W-1:0] a, input logic [W-1:0] m,
                                        input logic [W-1:0] b);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < W; i++) begin
      int n;
      n = 0;
      for (int j = i - 1; j <= i + 1; j++) begin
        if (j >= 0 && j < W) begin
          if (a[j]) n++;
          if (b[j]) n++;
          if (j != i && m[j]) n++;
        end
      end
      res[i] = (n == 3) || (m[i] && n == 2);
    end
    return res;
  endfunction

  always_comb bus.calc_new_i = life(bus.calc_arriba_o, bus.calc_medio_o, bus.calc_abajo_o);

  typedef struct {
    int           phase;
    logic [R-1:0] row;
    logic [W-1:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_phase(input int p);
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        bus.rd_row_i = vecs[i].row;
        #1;
        check($sformatf("phase%0d row%0d", p, vecs[i].row), 32'(bus.rd_data_o), 32'(vecs[i].exp));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_row(input logic [R-1:0] row, input logic [W-1:0] data);
    @(negedge clk);
    bus.load_i = 1'b1; bus.load_row_i = row; bus.load_data_i = data;
    @(negedge clk);
    bus.load_i = 1'b0;
  endtask

  // Cycle n counts from the first cycle after the edge that samples step_i.
  task automatic step_gen(input string tag);
    int busy_n, done_n, done_cnt;
    @(negedge clk);
    bus.step_i = 1'b1;
    @(negedge clk);
    bus.step_i = 1'b0;
    busy_n = 0; done_n = 0; done_cnt = 0;
    for (int n = 1; n <= H + 4; n++) begin
      if (bus.busy_o) busy_n++;
      if (bus.done_o) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (n == 1) check({tag, " busy@k+1"}, 32'(bus.busy_o), 32'd1);
      if (n < H + 4) @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(busy_n), 32'(H));
    check({tag, " done cycle"}, 32'(done_n), 32'(H + 1));
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int waited;

    for (int i = 0; i < H; i++)
      vecs.push_back('{1, R'(i), (i >= 8 && i <= 10) ? 20'h00200 : 20'h0});
    vecs.push_back('{2, R'(8),  20'h00000});
    vecs.push_back('{2, R'(9),  20'h00700});
    vecs.push_back('{2, R'(10), 20'h00000});
    vecs.push_back('{3, R'(0),  20'h00003});
    vecs.push_back('{3, R'(1),  20'h00003});
    vecs.push_back('{3, R'(2),  20'h00000});
    vecs.push_back('{4, R'(18), 20'h00000});
    vecs.push_back('{4, R'(19), 20'h00000});
    vecs.push_back('{4, R'(31), 20'h00000});
    for (int i = 0; i < H; i++) vecs.push_back('{5, R'(i), 20'h0});
    vecs.push_back('{6, R'(3),  20'h12345});
    vecs.push_back('{7, R'(0),  20'h00000});
    vecs.push_back('{7, R'(9),  20'h00700});

    bus.load_i = 1'b0; bus.load_row_i = '0; bus.load_data_i = '0;
    bus.step_i = 1'b0; bus.rd_row_i = '0;

    do_reset();
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst done", 32'(bus.done_o), 32'd0);
    check("rst extinct", 32'(bus.extinct_o), 32'd0);
    check("rst gen_count", 32'(bus.gen_count_o), 32'd0);
    check("rst calc", 32'(bus.calc_arriba_o | bus.calc_medio_o | bus.calc_abajo_o), 32'd0);

    // Blinker: horizontal -> vertical -> horizontal
    load_row(5'd9, 20'h00700);
    step_gen("blinker1");
    check("blinker1 gen", 32'(bus.gen_count_o), 32'd1);
    check("blinker1 extinct", 32'(bus.extinct_o), 32'd0);
    check("idle calc", 32'(bus.calc_arriba_o | bus.calc_medio_o | bus.calc_abajo_o), 32'd0);
    check_phase(1);
    step_gen("blinker2");
    check("blinker2 gen", 32'(bus.gen_count_o), 32'd2);
    check_phase(2);

    // Corner still life at top edge / bit 0
    do_reset();
    load_row(5'd0, 20'h00003);
    load_row(5'd1, 20'h00003);
    step_gen("corner1");
    step_gen("corner2");
    step_gen("corner3");
    check("corner gen", 32'(bus.gen_count_o), 32'd3);
    check("corner extinct", 32'(bus.extinct_o), 32'd0);
    check_phase(3);

    // Extinction from a lone cell at bottom-right
    do_reset();
    load_row(5'd19, 20'h80000);
    step_gen("extinct");
    check("extinct flag", 32'(bus.extinct_o), 32'd1);
    check("extinct gen", 32'(bus.gen_count_o), 32'd1);
    check_phase(4);

    // Load and step together: load applied, step dropped
    do_reset();
    @(negedge clk);
    bus.load_i = 1'b1; bus.load_row_i = 5'd3; bus.load_data_i = 20'h12345; bus.step_i = 1'b1;
    @(negedge clk);
    bus.load_i = 1'b0; bus.step_i = 1'b0;
    check("load+step busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    check("load+step busy2", 32'(bus.busy_o), 32'd0);
    check_phase(6);

    // Busy guard: step held 30 cycles, load pulsed mid-run
    do_reset();
    load_row(5'd9, 20'h00700);
    @(negedge clk);
    bus.step_i = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done_o) done_cnt++;
      if (i == 5) begin
        bus.load_i = 1'b1; bus.load_row_i = 5'd0; bus.load_data_i = 20'hFFFFF;
      end
      if (i == 6) bus.load_i = 1'b0;
    end
    bus.step_i = 1'b0;
    check("guard done pulses", 32'(done_cnt), 32'd1);
    check("guard gen", 32'(bus.gen_count_o), 32'd1);
    // The held step re-armed a second generation after DONE; let it finish.
    waited = 0;
    while (!bus.done_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("guard second done seen", 32'(bus.done_o), 32'd1);
    @(negedge clk);
    check("guard gen final", 32'(bus.gen_count_o), 32'd2);
    check_phase(7);

    // Reset while processing row 5
    do_reset();
    load_row(5'd9, 20'h00700);
    @(negedge clk);
    bus.step_i = 1'b1;
    @(negedge clk);
    bus.step_i = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst busy before", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 32'(bus.busy_o), 32'd0);
    check("midrst gen", 32'(bus.gen_count_o), 32'd0);
    check("midrst calc", 32'(bus.calc_arriba_o | bus.calc_medio_o | bus.calc_abajo_o), 32'd0);
    check_phase(5);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done_o || bus.busy_o) done_cnt++;
      @(negedge clk);
    end
    check("midrst no done/busy", 32'(done_cnt), 32'd0);

    // Generation counter wrap
    do_reset();
    @(negedge clk);
    force dut.gen_count = 16'hFFFF;
    @(negedge clk);
    release dut.gen_count;
    @(negedge clk);
    check("wrap preset", 32'(bus.gen_count_o), 32'h0000FFFF);
    step_gen("wrap");
    check("wrap gen", 32'(bus.gen_count_o), 32'd0);
    check("wrap extinct", 32'(bus.extinct_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
